ext_ram_arbiter: RTL and testbench
==================================

EXT_RAM_ARBITER -- requirements
Module: ext_ram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SRAM access length in clocks; legal range 2..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetB  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1 each  transaction request from requester 0 / 1.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; qualified by reqN.
REQ-006 addr0, addr1  input  19 each  byte address.
REQ-007 wdata0, wdata1  input  8 each  write data.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-009 rdata0, rdata1  output  8 each  registered read data per requester.
REQ-010 externalRamCEB, externalRamWEB, externalRamOEB  output  1 each  SRAM strobes, active-low.
REQ-011 externalRamAddress  output  19  registered SRAM address.
REQ-012 externalRamWriteData  output  8  registered data to pad driver.
REQ-013 externalRamDataOE  output  1  1 = drive externalRamWriteData onto the SRAM data bus.
REQ-014 externalRamReadData  input  8  SRAM data bus as seen by the arbiter.

Function
REQ-015 FSM states IDLE, ACCESS, RECOVER; transitions IDLE->ACCESS on any req, ACCESS->RECOVER after WAIT_CYCLES cycles, RECOVER->IDLE unconditionally.
REQ-016 reqN sampled only in IDLE; requests in ACCESS/RECOVER wait.
REQ-017 Grant in IDLE: single request -> that port; both -> port named by round-robin pointer.
REQ-018 Pointer set to the non-granted port at each grant; fairness: with both ports requesting continuously, grants alternate 0,1,0,1...
REQ-019 On the IDLE->ACCESS edge: externalRamAddress, externalRamWriteData, direction, granted port are latched; these stay stable through ACCESS and RECOVER.
REQ-020 ACCESS: externalRamCEB = 0 in every ACCESS cycle; count cycles with 4-bit counter cleared on entry.
REQ-021 Read in ACCESS: externalRamOEB = 0 all cycles, externalRamWEB = 1, externalRamDataOE = 0.
REQ-022 Write in ACCESS: externalRamDataOE = 1 all cycles, externalRamOEB = 1, externalRamWEB = 0 in cycles 2..WAIT_CYCLES only (cycle 1 = address setup).
REQ-023 Read data captured from externalRamReadData on the edge ending the final ACCESS cycle into rdataN of granted port; other port's rdata unchanged.
REQ-024 RECOVER: all strobes = 1, externalRamDataOE = 0; ackN of granted port = 1 for exactly this cycle; rdataN valid from this cycle until that port's next read completion.
REQ-025 Latency: req sampled at edge k -> ACCESS cycles k+1..k+WAIT_CYCLES -> ack in cycle k+WAIT_CYCLES+1; throughput one transaction per WAIT_CYCLES+2 clocks.
REQ-026 Requester holds req/we/addr/wdata until ack and deasserts req on the edge ending the ack cycle; req still high in following IDLE is a new transaction.
REQ-027 ack0 and ack1 never high together; externalRamWEB and externalRamOEB never low together.

Reset
REQ-028 resetB low immediately forces: state IDLE, externalRamCEB/WEB/OEB = 1, externalRamDataOE = 0, ack0/ack1 = 0, externalRamAddress = 0, externalRamWriteData = 0, rdata0/rdata1 = 0, counter = 0, pointer = port 0.
REQ-029 Reset during ACCESS aborts the transaction: no ack is issued, no rdata update; after resetB rises, first request is sampled at the next rising edge.

Verification
REQ-030 Single read, WAIT_CYCLES=2: req0=1, we0=0, addr0=0x00010, SRAM model holds 0xA5 -> CEB/OEB low 2 cycles, ack0 pulse 3 cycles after sample, rdata0=0xA5.
REQ-031 Single write: req1=1, we1=1, addr1=0x7FFFF, wdata1=0x3C -> DataOE high 2 cycles, WEB low only in ACCESS cycle 2, model location 0x7FFFF = 0x3C, ack1 pulse.
REQ-032 Simultaneous req0/req1 after reset -> port 0 served first, then port 1; continuous requests from both yield grant order 0,1,0,1 and no overlapping acks.
REQ-033 WAIT_CYCLES=5 read -> CEB low exactly 5 cycles, ack 6 cycles after sample, strobes high in RECOVER.
REQ-034 resetB pulsed low in second ACCESS cycle of a write -> strobes high and DataOE low asynchronously, no ack, rdata0/rdata1 = 0, next request completes normally.

Source files
------------

// File: rtl/ext_ram_arbiter.sv
// Two-port arbiter for an external asynchronous SRAM: round-robin grant, fixed-length
// access window, one recovery cycle carrying the acknowledge.
module ext_ram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetB,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [18:0] addr0,
  input  logic [18:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        externalRamCEB,
  output logic        externalRamWEB,
  output logic        externalRamOEB,
  output logic [18:0] externalRamAddress,
  output logic [7:0]  externalRamWriteData,
  output logic        externalRamDataOE,
  input  logic [7:0]  externalRamReadData
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRecover
  } stateE;

  localparam logic [3:0] LastCount = 4'(WAIT_CYCLES - 1);

  stateE      state;
  logic [3:0] cycleCount;
  logic       pointer;
  logic       grantPort;
  logic       writeOp;
  logic       grantNext;
  logic       weNext;

  // Both requesting: the pointer decides; otherwise whichever port is asking.
  always_comb begin
    grantNext = (req0 && req1) ? pointer : req1;
    weNext    = grantNext ? we1 : we0;
  end

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state                <= StIdle;
      cycleCount           <= 4'd0;
      pointer              <= 1'b0;
      grantPort            <= 1'b0;
      writeOp              <= 1'b0;
      ack0                 <= 1'b0;
      ack1                 <= 1'b0;
      rdata0               <= 8'd0;
      rdata1               <= 8'd0;
      externalRamCEB       <= 1'b1;
      externalRamWEB       <= 1'b1;
      externalRamOEB       <= 1'b1;
      externalRamAddress   <= 19'd0;
      externalRamWriteData <= 8'd0;
      externalRamDataOE    <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        StIdle: begin
          if (req0 || req1) begin
            state                <= StAccess;
            cycleCount           <= 4'd0;
            grantPort            <= grantNext;
            pointer              <= ~grantNext;
            writeOp              <= weNext;
            externalRamAddress   <= grantNext ? addr1 : addr0;
            externalRamWriteData <= grantNext ? wdata1 : wdata0;
            externalRamCEB       <= 1'b0;
            externalRamOEB       <= weNext;
            externalRamDataOE    <= weNext;
          end
        end
        StAccess: begin
          if (cycleCount == LastCount) begin
            state             <= StRecover;
            externalRamCEB    <= 1'b1;
            externalRamWEB    <= 1'b1;
            externalRamOEB    <= 1'b1;
            externalRamDataOE <= 1'b0;
            if (grantPort) begin
              ack1 <= 1'b1;
            end else begin
              ack0 <= 1'b1;
            end
            if (!writeOp) begin
              if (grantPort) begin
                rdata1 <= externalRamReadData;
              end else begin
                rdata0 <= externalRamReadData;
              end
            end
          end else begin
            // First access cycle is address setup; WEB falls from the second one on.
            cycleCount     <= cycleCount + 4'd1;
            externalRamWEB <= ~writeOp;
          end
        end
        StRecover: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_ram_arbiter.sv
// Bench for ext_ram_arbiter: two instances (WAIT_CYCLES 2 and 5), each with its own SRAM
// image and requesters, compared against a transaction-timeline reference model.
module tb_ext_ram_arbiter;

  localparam int WaitA = 2;
  localparam int WaitB = 5;
  localparam logic [48:0] ResetVec = {4'b1110, 2'b00, 43'd0};

  logic clk = 1'b0;
  logic resetB = 1'b1;
  always #5 clk = ~clk;

  logic        req   [2][2];
  logic        we    [2][2];
  logic [18:0] addr  [2][2];
  logic [7:0]  wdata [2][2];
  logic        ack   [2][2];
  logic [7:0]  rdata [2][2];
  logic        ceb [2];
  logic        web [2];
  logic        oeb [2];
  logic        dataOe [2];
  logic [18:0] ramAddr [2];
  logic [7:0]  ramWdata [2];
  logic [7:0]  ramRdata [2];

  int passCount = 0;
  int checkCount = 0;

  ext_ram_arbiter #(.WAIT_CYCLES(WaitA)) dutA (
    .clk(clk), .resetB(resetB),
    .req0(req[0][0]), .req1(req[0][1]), .we0(we[0][0]), .we1(we[0][1]),
    .addr0(addr[0][0]), .addr1(addr[0][1]), .wdata0(wdata[0][0]), .wdata1(wdata[0][1]),
    .ack0(ack[0][0]), .ack1(ack[0][1]), .rdata0(rdata[0][0]), .rdata1(rdata[0][1]),
    .externalRamCEB(ceb[0]), .externalRamWEB(web[0]), .externalRamOEB(oeb[0]),
    .externalRamAddress(ramAddr[0]), .externalRamWriteData(ramWdata[0]),
    .externalRamDataOE(dataOe[0]), .externalRamReadData(ramRdata[0])
  );

  ext_ram_arbiter #(.WAIT_CYCLES(WaitB)) dutB (
    .clk(clk), .resetB(resetB),
    .req0(req[1][0]), .req1(req[1][1]), .we0(we[1][0]), .we1(we[1][1]),
    .addr0(addr[1][0]), .addr1(addr[1][1]), .wdata0(wdata[1][0]), .wdata1(wdata[1][1]),
    .ack0(ack[1][0]), .ack1(ack[1][1]), .rdata0(rdata[1][0]), .rdata1(rdata[1][1]),
    .externalRamCEB(ceb[1]), .externalRamWEB(web[1]), .externalRamOEB(oeb[1]),
    .externalRamAddress(ramAddr[1]), .externalRamWriteData(ramWdata[1]),
    .externalRamDataOE(dataOe[1]), .externalRamReadData(ramRdata[1])
  );

  // SRAM images (actual, written by the strobes) and expected (written by the model).
  logic [7:0] sram [int];
  logic [7:0] expMem [int];

  function automatic int waitOf(int d);
    return (d == 0) ? WaitA : WaitB;
  endfunction

  function automatic int keyOf(int d, logic [18:0] a);
    return (d << 19) | int'(a);
  endfunction

  function automatic logic [7:0] initVal(int k);
    logic [18:0] a;
    a = k[18:0];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] sramRead(int k);
    return sram.exists(k) ? sram[k] : initVal(k);
  endfunction

  function automatic logic [7:0] expRead(int k);
    return expMem.exists(k) ? expMem[k] : initVal(k);
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ramRdata[d] = (ceb[d] === 1'b0 && oeb[d] === 1'b0) ? sramRead(keyOf(d, ramAddr[d])) : 8'h00;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (resetB && ceb[d] === 1'b0 && web[d] === 1'b0 && dataOe[d] === 1'b1) begin
        sram[keyOf(d, ramAddr[d])] = ramWdata[d];
      end
    end
  end

  // Reference: phase 0 = idle, 1..W = access cycles, W+1 = acknowledge cycle.
  int          phase [2];
  logic        ptr [2];
  logic        mPort [2];
  logic        mWe [2];
  logic [18:0] mAddr [2];
  logic [7:0]  mWdata [2];
  logic [7:0]  mRdata [2][2];

  always @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      for (int d = 0; d < 2; d++) begin
        phase[d] = 0; ptr[d] = 1'b0; mPort[d] = 1'b0; mWe[d] = 1'b0;
        mAddr[d] = '0; mWdata[d] = '0; mRdata[d][0] = '0; mRdata[d][1] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (phase[d] == 0) begin
          if (req[d][0] || req[d][1]) begin
            mPort[d]  = (req[d][0] && req[d][1]) ? ptr[d] : req[d][1];
            ptr[d]    = !mPort[d];
            mWe[d]    = we[d][mPort[d]];
            mAddr[d]  = addr[d][mPort[d]];
            mWdata[d] = wdata[d][mPort[d]];
            phase[d]  = 1;
          end
        end else if (phase[d] == waitOf(d) + 1) begin
          phase[d] = 0;
        end else begin
          phase[d]++;
          if (phase[d] == waitOf(d) + 1) begin
            if (mWe[d]) expMem[keyOf(d, mAddr[d])] = mWdata[d];
            else mRdata[d][mPort[d]] = expRead(keyOf(d, mAddr[d]));
          end
        end
      end
    end
  end

  function automatic logic [48:0] gotVec(int d);
    return {ceb[d], oeb[d], web[d], dataOe[d], ack[d][0], ack[d][1], ramAddr[d], ramWdata[d],
            rdata[d][0], rdata[d][1]};
  endfunction

  function automatic logic [48:0] expVec(int d);
    int w;
    int p;
    logic acc;
    logic wr;
    w = waitOf(d);
    p = phase[d];
    acc = (p >= 1 && p <= w);
    wr = mWe[d];
    return {!acc, !(acc && !wr), !(p >= 2 && p <= w && wr), acc && wr,
            (p == w + 1) && !mPort[d], (p == w + 1) && mPort[d], mAddr[d], mWdata[d],
            mRdata[d][0], mRdata[d][1]};
  endfunction

  task automatic clearInputs();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0;
      end
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    resetB = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    resetB = 1'b1;
  endtask

  task automatic test_reset();
    clearInputs();
    #1 resetB = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkCount++;
      if (gotVec(d) !== ResetVec) $display("FAIL reset_values dut%0d got %h want %h", d, gotVec(d), ResetVec);
      else passCount++;
    end
    resetB = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkCount++;
      if (gotVec(d) !== ResetVec) $display("FAIL idle_after_reset dut%0d got %h want %h", d, gotVec(d), ResetVec);
      else passCount++;
    end
  endtask

  task automatic test_fairness();
    int order [2][6];
    int nAck [2];
    applyReset();
    nAck[0] = 0; nAck[1] = 0;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b1; we[d][p] = 1'b0; addr[d][p] = 19'(16 + d * 4 + p);
      end
    end
    for (int cyc = 0; cyc < 100 && (nAck[0] < 6 || nAck[1] < 6); cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checkCount++;
        if (ack[d][0] && ack[d][1]) $display("FAIL ack_overlap dut%0d got both acks want one", d);
        else passCount++;
        if ((ack[d][0] || ack[d][1]) && nAck[d] < 6) begin
          order[d][nAck[d]] = int'(ack[d][1]);
          nAck[d]++;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 6; i++) begin
        checkCount++;
        if (i >= nAck[d]) $display("FAIL grant_order dut%0d slot%0d got no ack want port %0d", d, i, i % 2);
        else if (order[d][i] != i % 2)
          $display("FAIL grant_order dut%0d slot%0d got port %0d want port %0d", d, i, order[d][i], i % 2);
        else passCount++;
      end
    end
    clearInputs();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single_read();
    int cebLow [2];
    int oebLow [2];
    int ackAt [2];
    applyReset();
    for (int d = 0; d < 2; d++) begin
      sram[keyOf(d, 19'h00010)] = 8'hA5;
      expMem[keyOf(d, 19'h00010)] = 8'hA5;
      cebLow[d] = 0; oebLow[d] = 0; ackAt[d] = 0;
      req[d][0] = 1'b1; we[d][0] = 1'b0; addr[d][0] = 19'h00010;
    end
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ceb[d] == 1'b0) cebLow[d]++;
        if (oeb[d] == 1'b0) oebLow[d]++;
        if (ack[d][0]) begin
          ackAt[d] = n;
          req[d][0] = 1'b0;
          checkCount++;
          if ({ceb[d], oeb[d], web[d], dataOe[d]} !== 4'b1110)
            $display("FAIL read_recover_strobes dut%0d got %b want 1110", d, {ceb[d], oeb[d], web[d], dataOe[d]});
          else passCount++;
          checkCount++;
          if (rdata[d][0] !== 8'hA5) $display("FAIL read_rdata0 dut%0d got %h want a5", d, rdata[d][0]);
          else passCount++;
          checkCount++;
          if (rdata[d][1] !== 8'h00) $display("FAIL read_rdata1_kept dut%0d got %h want 00", d, rdata[d][1]);
          else passCount++;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checkCount++;
      if (cebLow[d] != waitOf(d)) $display("FAIL read_ceb_cycles dut%0d got %0d want %0d", d, cebLow[d], waitOf(d));
      else passCount++;
      checkCount++;
      if (oebLow[d] != waitOf(d)) $display("FAIL read_oeb_cycles dut%0d got %0d want %0d", d, oebLow[d], waitOf(d));
      else passCount++;
      checkCount++;
      if (ackAt[d] != waitOf(d) + 1) $display("FAIL read_ack_latency dut%0d got %0d want %0d", d, ackAt[d], waitOf(d) + 1);
      else passCount++;
    end
  endtask

  task automatic test_single_write();
    int oeHigh [2];
    int webLow [2];
    int firstWeb [2];
    int ackAt [2];
    int wrongAck [2];
    applyReset();
    for (int d = 0; d < 2; d++) begin
      oeHigh[d] = 0; webLow[d] = 0; firstWeb[d] = 0; ackAt[d] = 0; wrongAck[d] = 0;
      req[d][1] = 1'b1; we[d][1] = 1'b1; addr[d][1] = 19'h7FFFF; wdata[d][1] = 8'h3C;
    end
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (dataOe[d] == 1'b1) oeHigh[d]++;
        if (web[d] == 1'b0) begin
          webLow[d]++;
          if (firstWeb[d] == 0) firstWeb[d] = n;
        end
        if (ack[d][0]) wrongAck[d]++;
        if (ack[d][1]) begin
          ackAt[d] = n;
          req[d][1] = 1'b0;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checkCount++;
      if (oeHigh[d] != waitOf(d)) $display("FAIL write_dataoe_cycles dut%0d got %0d want %0d", d, oeHigh[d], waitOf(d));
      else passCount++;
      checkCount++;
      if (webLow[d] != waitOf(d) - 1) $display("FAIL write_web_cycles dut%0d got %0d want %0d", d, webLow[d], waitOf(d) - 1);
      else passCount++;
      checkCount++;
      if (firstWeb[d] != 2) $display("FAIL write_web_start dut%0d got %0d want 2", d, firstWeb[d]);
      else passCount++;
      checkCount++;
      if (ackAt[d] != waitOf(d) + 1 || wrongAck[d] != 0)
        $display("FAIL write_ack1 dut%0d got cycle %0d (ack0 x%0d) want cycle %0d", d, ackAt[d], wrongAck[d], waitOf(d) + 1);
      else passCount++;
      checkCount++;
      if (sramRead(keyOf(d, 19'h7FFFF)) !== 8'h3C)
        $display("FAIL write_memory dut%0d got %h want 3c", d, sramRead(keyOf(d, 19'h7FFFF)));
      else passCount++;
    end
  endtask

  task automatic test_reset_abort();
    int ackAt [2];
    int earlyAck [2];
    applyReset();
    for (int d = 0; d < 2; d++) begin
      ackAt[d] = 0; earlyAck[d] = 0;
      req[d][0] = 1'b1; we[d][0] = 1'b1; addr[d][0] = 19'h00123; wdata[d][0] = 8'h99;
    end
    @(posedge clk);
    @(posedge clk);
    #2 resetB = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkCount++;
      if ({ceb[d], oeb[d], web[d], dataOe[d], ack[d][0], ack[d][1], rdata[d][0], rdata[d][1]} !== {6'b111000, 16'h0})
        $display("FAIL abort_async_outputs dut%0d got %b %h %h want 111000 00 00", d,
                 {ceb[d], oeb[d], web[d], dataOe[d], ack[d][0], ack[d][1]}, rdata[d][0], rdata[d][1]);
      else passCount++;
      checkCount++;
      if (sramRead(keyOf(d, 19'h00123)) !== initVal(keyOf(d, 19'h00123)))
        $display("FAIL abort_no_write dut%0d got %h want %h", d, sramRead(keyOf(d, 19'h00123)),
                 initVal(keyOf(d, 19'h00123)));
      else passCount++;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) if (ack[d][0] || ack[d][1]) earlyAck[d]++;
    resetB = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ack[d][0] && ackAt[d] == 0) begin
          ackAt[d] = n;
          req[d][0] = 1'b0;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checkCount++;
      if (earlyAck[d] != 0 || ackAt[d] != waitOf(d) + 1)
        $display("FAIL abort_retry_ack dut%0d got cycle %0d (acks in reset %0d) want cycle %0d", d, ackAt[d],
                 earlyAck[d], waitOf(d) + 1);
      else passCount++;
      checkCount++;
      if (sramRead(keyOf(d, 19'h00123)) !== 8'h99)
        $display("FAIL abort_retry_memory dut%0d got %h want 99", d, sramRead(keyOf(d, 19'h00123)));
      else passCount++;
    end
  endtask

  task automatic test_random();
    int left [2][2];
    int gap [2][2];
    logic active [2][2];
    bit done;
    done = 1'b0;
    applyReset();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        left[d][p] = 15; gap[d][p] = int'($urandom_range(0, 3)); active[d][p] = 1'b0;
      end
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checkCount++;
        if (gotVec(d) !== expVec(d))
          $display("FAIL random_cycle dut%0d cyc%0d got %h want %h", d, cyc, gotVec(d), expVec(d));
        else passCount++;
      end
      done = 1'b1;
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (active[d][p] && ack[d][p]) begin
            active[d][p] = 1'b0;
            req[d][p] = 1'b0;
            gap[d][p] = int'($urandom_range(0, 3));
          end else if (!active[d][p]) begin
            if (gap[d][p] > 0) gap[d][p]--;
            else if (left[d][p] > 0) begin
              left[d][p]--;
              active[d][p] = 1'b1;
              req[d][p] = 1'b1;
              we[d][p] = 1'($urandom_range(0, 1));
              addr[d][p] = 19'($urandom_range(0, 7)) | (19'($urandom_range(0, 3)) << 17);
              wdata[d][p] = 8'($urandom);
            end
          end
          if (active[d][p] || left[d][p] > 0) done = 1'b0;
        end
      end
      if (done) break;
    end
    checkCount++;
    if (!done) $display("FAIL random_timeout got unfinished transactions want all acknowledged");
    else passCount++;
    repeat (2) @(negedge clk);
    foreach (expMem[k]) begin
      checkCount++;
      if (sramRead(k) !== expMem[k]) $display("FAIL random_memory key %h got %h want %h", k, sramRead(k), expMem[k]);
      else passCount++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) ramRdata[d] = 8'h00;
    test_reset();
    test_fairness();
    test_single_read();
    test_single_write();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
